// File: rtl/serial_link_master.sv
// serial_link_master
//   Frame-level initiator for the MUX serial bias/monitor link. Each frame
//   shifts a TX_WIDTH-bit command out on mosi, MSB first. It then shifts an
//   RX_WIDTH-bit response in from miso. The slave samples mosi on the rising
//   sclk edge and updates miso on the falling sclk edge.
//
// Parameters
//   TX_WIDTH     command bits per frame (>= 1)
//   RX_WIDTH     response bits per frame (0 = write-only frame)
//   HALF_PERIOD  CLK cycles per sclk half-period (>= 2)
//
// Ports
//   CLK      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   frame request, honoured only while idle
//   txData   in   command word, latched when start is accepted
//   busy     out  frame in progress
//   done     out  one-cycle pulse in the cycle after the frame ends
//   rxData   out  last captured response (MSB = first bit received)
//   sclk     out  serial clock, idles low
//   ss_n     out  active-low slave select
//   mosi     out  serial data to slave
//   miso     in   serial data from slave (asynchronous to CLK)
module serial_link_master #(
  parameter int TX_WIDTH    = 5,
  parameter int RX_WIDTH    = 8,
  parameter int HALF_PERIOD = 4
) (
  input  logic                                       CLK,
  input  logic                                       reset_n,
  input  logic                                       start,
  input  logic [TX_WIDTH-1:0]                        txData,
  output logic                                       busy,
  output logic                                       done,
  output logic [((RX_WIDTH > 0) ? RX_WIDTH : 1)-1:0] rxData,
  output logic                                       sclk,
  output logic                                       ss_n,
  output logic                                       mosi,
  input  logic                                       miso
);

  localparam int RX_W   = (RX_WIDTH > 0) ? RX_WIDTH : 1;
  localparam int N_BITS = TX_WIDTH + RX_WIDTH;
  localparam int BIT_W  = $clog2(N_BITS + 1);
  localparam int PH_W   = $clog2(HALF_PERIOD);

  localparam logic [BIT_W-1:0] BITS_INIT = BIT_W'(N_BITS);
  localparam logic [BIT_W-1:0] RX_BITS   = BIT_W'(RX_WIDTH);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [PH_W-1:0]  PH_INIT   = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2
  } stateT;

  stateT               state;
  stateT               stateNext;
  logic [PH_W-1:0]     phaseCnt;
  logic [BIT_W-1:0]    bitCnt;
  logic [TX_WIDTH-1:0] txShift;
  logic [TX_WIDTH-1:0] txShiftNext;
  logic [RX_W-1:0]     rxShift;
  logic [1:0]          misoSync;

  logic phaseEnd;
  logic accept;
  logic riseEv;
  logic fallEv;
  logic frameEnd;
  logic txFall;
  logic rxFall;
  logic nextIsTx;

  // Next-state and event decode
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    riseEv    = 1'b0;
    fallEv    = 1'b0;
    frameEnd  = 1'b0;
    phaseEnd  = (phaseCnt == '0);
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = SETUP;
          accept    = 1'b1;
        end
      end
      SETUP: begin
        if (phaseEnd) begin
          stateNext = SHIFT;
          riseEv    = 1'b1;
        end
      end
      SHIFT: begin
        if (phaseEnd) begin
          if (sclk) begin
            fallEv = 1'b1;
          end else if (bitCnt == '0) begin
            // bitCnt counts down on each fall, so zero here means the low
            // phase of the final bit has just completed.
            stateNext = IDLE;
            frameEnd  = 1'b1;
          end else begin
            riseEv = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The bit ending at this fall is a TX bit while more than RX_WIDTH bits
  // remain; the following bit is still TX if more than RX_WIDTH+1 remain.
  assign txFall      = fallEv && (bitCnt > RX_BITS);
  assign rxFall      = fallEv && (bitCnt <= RX_BITS) && (RX_WIDTH > 0);
  assign nextIsTx    = (bitCnt - BIT_ONE) > RX_BITS;
  assign txShiftNext = txShift << 1;

  // State register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Link control and pin registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rxData   <= '0;
      sclk     <= 1'b0;
      ss_n     <= 1'b1;
      mosi     <= 1'b0;
      phaseCnt <= '0;
      bitCnt   <= '0;
    end else begin
      done <= frameEnd;
      if (accept) begin
        busy     <= 1'b1;
        ss_n     <= 1'b0;
        sclk     <= 1'b0;
        mosi     <= txData[TX_WIDTH-1];
        phaseCnt <= PH_INIT;
        bitCnt   <= BITS_INIT;
      end else if (riseEv) begin
        sclk     <= 1'b1;
        phaseCnt <= PH_INIT;
      end else if (fallEv) begin
        sclk     <= 1'b0;
        phaseCnt <= PH_INIT;
        bitCnt   <= bitCnt - BIT_ONE;
        if (txFall) begin
          mosi <= nextIsTx ? txShiftNext[TX_WIDTH-1] : 1'b0;
        end
      end else if (frameEnd) begin
        busy <= 1'b0;
        ss_n <= 1'b1;
        sclk <= 1'b0;
        mosi <= 1'b0;
        if (RX_WIDTH > 0) begin
          rxData <= rxShift;
        end
      end else if (state != IDLE) begin
        phaseCnt <= phaseCnt - PH_ONE;
      end
    end
  end

  // Shift datapath; the capture samples the synchronized miso on the edge
  // that ends each RX high phase, a full sclk period after the slave update.
  always_ff @(posedge CLK) begin
    misoSync <= {misoSync[0], miso};
    if (accept) begin
      txShift <= txData;
    end else if (txFall) begin
      txShift <= txShiftNext;
    end
    if (rxFall) begin
      rxShift <= (rxShift << 1) | RX_W'(misoSync[1]);
    end
  end

endmodule
